simple_loader: RTL and testbench



---
 rtl/simple_loader_pkg.sv | 23 ++
 rtl/simple_loader_if.sv | 23 ++
 rtl/simple_loader.sv | 200 ++++++++++++++++++++
 tb/tb_simple_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_loader_pkg.sv
// rtl/simple_loader_pkg.sv - shared state encoding and constants for the boot loader
package simple_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_H,
        ST_LEN_L,
        ST_DATA_H,
        ST_DATA_L,
        ST_WRITE,
        ST_CKSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0] HDR_BYTE    = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CKSUM   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/simple_loader_if.sv
// rtl/simple_loader_if.sv - byte stream in and RAM write port out of the boot loader
interface simple_loader_if #(
    parameter int ADDR_W = 16
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic              mem_wren;

    // loader side
    modport master (
        input  rx_valid, rx_data,
        output rx_ready, mem_addr, mem_data, mem_wren
    );

    // byte source / RAM side
    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, mem_addr, mem_data, mem_wren
    );
endinterface

// File: rtl/simple_loader.sv
// rtl/simple_loader.sv - framed byte loader into CPU RAM; LOADER_TIMEOUT_EN adds an inter-byte timeout
module simple_loader
    import simple_loader_pkg::*;
#(
    parameter int                ADDR_W         = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int                MAX_WORDS      = 4096,
    parameter logic [19:0]       TIMEOUT_CYCLES = 20'd1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    simple_loader_if.master   bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] words_loaded
);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        ck_q, ck_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic [ADDR_W-1:0] words_q, words_d;
    logic [1:0]        code_q, code_d;
`ifdef LOADER_TIMEOUT_EN
    logic [19:0]       tmr_q, tmr_d;
`endif

    logic        rx_ready_c;
    logic        accept;
    logic [15:0] n_c;
    logic [31:0] words_inc;

    // Handshake: only byte-consuming states take data, and restart blocks the byte
    always_comb begin
        rx_ready_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_LEN_H, ST_LEN_L, ST_DATA_H, ST_DATA_L, ST_CKSUM: rx_ready_c = !restart;
            default: rx_ready_c = 1'b0;
        endcase
    end

    assign accept    = bus.rx_valid && rx_ready_c;
    assign n_c       = {len_q[15:8], bus.rx_data};
    assign words_inc = 32'(words_q) + 32'd1;

    // Next-state, checksum, write assembly and timeout logic
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        hi_d    = hi_q;
        ck_d    = ck_q;
        addr_d  = addr_q;
        data_d  = data_q;
        words_d = words_q;
        code_d  = code_q;
`ifdef LOADER_TIMEOUT_EN
        tmr_d   = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept && bus.rx_data == HDR_BYTE) begin
                    ck_d    = '0;
                    words_d = '0;
                    state_d = ST_LEN_H;
                end
            end
            ST_LEN_H: begin
                if (accept) begin
                    len_d[15:8] = bus.rx_data;
                    ck_d        = ck_q ^ bus.rx_data;
                    state_d     = ST_LEN_L;
                end
            end
            ST_LEN_L: begin
                if (accept) begin
                    len_d = n_c;
                    ck_d  = ck_q ^ bus.rx_data;
                    if (32'(n_c) > 32'(MAX_WORDS)) begin
                        code_d  = ERR_LEN;
                        state_d = ST_ERR;
                    end else if (n_c == 16'd0) begin
                        state_d = ST_CKSUM;
                    end else begin
                        state_d = ST_DATA_H;
                    end
                end
            end
            ST_DATA_H: begin
                if (accept) begin
                    hi_d    = bus.rx_data;
                    ck_d    = ck_q ^ bus.rx_data;
                    state_d = ST_DATA_L;
                end
            end
            ST_DATA_L: begin
                if (accept) begin
                    data_d  = {hi_q, bus.rx_data};
                    addr_d  = BASE_ADDR + words_q;
                    ck_d    = ck_q ^ bus.rx_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                words_d = ADDR_W'(words_inc);
                state_d = (words_inc == 32'(len_q)) ? ST_CKSUM : ST_DATA_H;
            end
            ST_CKSUM: begin
                if (accept) begin
                    if (bus.rx_data == ck_q) begin
                        state_d = ST_DONE;
                    end else begin
                        code_d  = ERR_CKSUM;
                        state_d = ST_ERR;
                    end
                end
            end
            default: ;
        endcase

`ifdef LOADER_TIMEOUT_EN
        // Counter runs only mid-frame while waiting for a byte; the write cycle holds it
        case (state_q)
            ST_LEN_H, ST_LEN_L, ST_DATA_H, ST_DATA_L, ST_CKSUM: begin
                if (accept) begin
                    tmr_d = '0;
                end else if (tmr_q == TIMEOUT_CYCLES) begin
                    tmr_d   = '0;
                    code_d  = ERR_TIMEOUT;
                    state_d = ST_ERR;
                end else begin
                    tmr_d = tmr_q + 20'd1;
                end
            end
            ST_WRITE: tmr_d = tmr_q;
            default:  tmr_d = '0;
        endcase
`endif

        // Restart overrides everything except the last write address
        if (restart) begin
            state_d = ST_IDLE;
            len_d   = '0;
            hi_d    = '0;
            ck_d    = '0;
            data_d  = '0;
            words_d = '0;
            code_d  = ERR_NONE;
`ifdef LOADER_TIMEOUT_EN
            tmr_d   = '0;
`endif
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            hi_q    <= '0;
            ck_q    <= '0;
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
            words_q <= '0;
            code_q  <= ERR_NONE;
`ifdef LOADER_TIMEOUT_EN
            tmr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            ck_q    <= ck_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            words_q <= words_d;
            code_q  <= code_d;
`ifdef LOADER_TIMEOUT_EN
            tmr_q   <= tmr_d;
`endif
        end
    end

    assign bus.rx_ready = rx_ready_c;
    assign bus.mem_addr = addr_q;
    assign bus.mem_data = data_q;
    assign bus.mem_wren = (state_q == ST_WRITE);

    assign done         = (state_q == ST_DONE);
    assign err          = (state_q == ST_ERR);
    assign cpu_hold     = (state_q != ST_DONE);
    assign err_code     = code_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_simple_loader.sv
// tb/tb_simple_loader.sv - directed and randomized frames checked against a frame-level model
module tb_simple_loader;

    localparam int          MAXW = 4;
    localparam logic [15:0] BASE = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    logic        cpu_hold, done, err;
    logic [1:0]  err_code;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    logic [15:0] wq[$];
    logic [7:0]  jq[$];

    always #5 clk = ~clk;

    simple_loader_if #(.ADDR_W(16)) bus ();

    simple_loader #(
        .ADDR_W(16),
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAXW),
        .TIMEOUT_CYCLES(20'd100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .restart(restart),
        .bus(bus),
        .cpu_hold(cpu_hold),
        .done(done),
        .err(err),
        .err_code(err_code),
        .words_loaded(words_loaded)
    );

    always @(negedge clk) begin
        if (bus.mem_wren === 1'b1) obs_q.push_back({bus.mem_addr, bus.mem_data});
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("rx_ready_wait", {31'd0, bus.rx_ready}, 32'd1);
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
    endtask

    // Frame model: junk from jq, header, length n, words from wq, then checksum.
    // ck_sel < 0 sends the correct checksum, otherwise ck_sel[7:0].
    task automatic run_frame(input string tag, input logic [15:0] n, input int ck_sel);
        logic [7:0]  ck;
        logic [7:0]  sent;
        logic [15:0] exp_words;
        bit          exp_done;
        logic [1:0]  exp_code;
        obs_q.delete();
        exp_q.delete();
        foreach (jq[i]) send_byte(jq[i]);
        send_byte(8'hA5);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        ck = n[15:8] ^ n[7:0];
        if (int'(n) > MAXW) begin
            exp_done  = 1'b0;
            exp_code  = 2'd1;
            exp_words = 16'd0;
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                send_byte(wq[i][15:8]);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                send_byte(wq[i][7:0]);
                ck = ck ^ wq[i][15:8] ^ wq[i][7:0];
                exp_q.push_back({BASE + 16'(i), wq[i]});
            end
            sent = (ck_sel < 0) ? ck : ck_sel[7:0];
            send_byte(sent);
            exp_done  = (sent == ck);
            exp_code  = exp_done ? 2'd0 : 2'd2;
            exp_words = n;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        chk({tag, "_err"}, {31'd0, err}, {31'd0, !exp_done});
        chk({tag, "_code"}, {30'd0, err_code}, {30'd0, exp_code});
        chk({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, !exp_done});
        chk({tag, "_rdy"}, {31'd0, bus.rx_ready}, 32'd0);
        chk({tag, "_words"}, {16'd0, words_loaded}, {16'd0, exp_words});
        chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) chk({tag, "_wr"}, obs_q[i], exp_q[i]);
        end
    endtask

    initial begin
        logic [15:0] rn;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", {31'd0, bus.rx_ready}, 32'd1);
        chk("rst_addr", {16'd0, bus.mem_addr}, {16'd0, BASE});
        chk("rst_data", {16'd0, bus.mem_data}, 32'd0);
        chk("rst_wren", {31'd0, bus.mem_wren}, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_code", {30'd0, err_code}, 32'd0);
        chk("rst_words", {16'd0, words_loaded}, 32'd0);
        rst_n = 1'b1;

        // two-word image
        jq = {};
        wq = {16'h1234, 16'hABCD};
        run_frame("f1", 16'd2, -1);

        // restart together with a header byte: byte refused, back to idle
        @(negedge clk);
        restart = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'hA5;
        #1 chk("rs_rdy_blocked", {31'd0, bus.rx_ready}, 32'd0);
        @(posedge clk);
        #1;
        restart = 1'b0;
        bus.rx_valid = 1'b0;
        chk("rs_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rs_done", {31'd0, done}, 32'd0);
        chk("rs_words", {16'd0, words_loaded}, 32'd0);
        chk("rs_data", {16'd0, bus.mem_data}, 32'd0);
        chk("rs_addr_kept", {16'd0, bus.mem_addr}, {16'd0, BASE + 16'd1});
        chk("rs_rdy", {31'd0, bus.rx_ready}, 32'd1);
        run_frame("f1b", 16'd2, -1);

        // leading junk, empty image
        do_restart();
        jq = {8'h00, 8'hFF};
        wq = {};
        run_frame("empty", 16'd0, -1);

        // bad checksum
        do_restart();
        jq = {};
        wq = {16'h55AA};
        run_frame("badck", 16'd1, 0);

        // length limits
        do_restart();
        run_frame("len5", 16'd5, -1);
        do_restart();
        run_frame("len256", 16'h0100, -1);
        do_restart();
        wq = {16'h0001, 16'hFFFF, 16'h8000, 16'h7E7E};
        run_frame("lenmax", 16'd4, -1);

        // restart during the write cycle
        do_restart();
        obs_q.delete();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        restart = 1'b1;
        chk("rw_wren", {31'd0, bus.mem_wren}, 32'd1);
        chk("rw_rdy", {31'd0, bus.rx_ready}, 32'd0);
        @(posedge clk);
        #1 restart = 1'b0;
        chk("rw_wren_after", {31'd0, bus.mem_wren}, 32'd0);
        chk("rw_words", {16'd0, words_loaded}, 32'd0);
        chk("rw_hold", {31'd0, cpu_hold}, 32'd1);
        @(negedge clk);
        chk("rw_nwr", obs_q.size(), 32'd1);
        if (obs_q.size() > 0) chk("rw_wr", obs_q[0], 32'h0000_1234);

        // async reset in the write cycle: strobe dies at once
        obs_q.delete();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h55); send_byte(8'hAA);
        rst_n = 1'b0;
        #1;
        chk("ar_wren", {31'd0, bus.mem_wren}, 32'd0);
        chk("ar_addr", {16'd0, bus.mem_addr}, {16'd0, BASE});
        chk("ar_hold", {31'd0, cpu_hold}, 32'd1);
        @(negedge clk);
        chk("ar_nwr", obs_q.size(), 32'd0);
        rst_n = 1'b1;

        // stall mid-frame after the length high byte
        send_byte(8'hA5);
        send_byte(8'h00);
        repeat (110) @(posedge clk);
        @(negedge clk);
`ifdef LOADER_TIMEOUT_EN
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_code", {30'd0, err_code}, 32'd3);
        do_restart();
`else
        chk("stall_err", {31'd0, err}, 32'd0);
        chk("stall_rdy", {31'd0, bus.rx_ready}, 32'd1);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (2) @(negedge clk);
        chk("stall_done", {31'd0, done}, 32'd1);
        do_restart();
`endif

        // randomized frames
        for (int f = 0; f < 10; f++) begin
            jq = {};
            repeat ($urandom_range(0, 2)) begin
                logic [7:0] j;
                j = 8'($urandom_range(0, 255));
                if (j == 8'hA5) j = 8'h5A;
                jq.push_back(j);
            end
            wq = {};
            rn = 16'($urandom_range(0, MAXW + 1));
            for (int i = 0; i < int'(rn); i++) wq.push_back(16'($urandom));
            run_frame("rnd", rn, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : -1);
            do_restart();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
